a2_demux_1_2_buf: RTL and testbench

Buffered 1:2 demultiplexer for the pipelined datapath. It steers a single 8-bit valid/ready stream to one of two destination streams, selected per word by `in_sel`. Each destination has its own small FIFO, so one stalled consumer does not lose data already routed to it. It is the splitting counterpart of the datapath's 2:1 select muxes, used where one stage's result feeds two downstream consumers.

---
 rtl/a2_pkg.sv | 10 +
 rtl/a2_fifo_sync.sv | 60 ++++++
 rtl/a2_demux_1_2_buf.sv | 65 ++++++
 tb/tb_a2_demux_1_2_buf.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/a2_pkg.sv
// Shared constants for the a2 datapath split/select blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package a2_pkg;

    localparam int   A2_DATA_W   = 8;
    localparam logic A2_SEL_OUT0 = 1'b0;
    localparam logic A2_SEL_OUT1 = 1'b1;

endpackage

// File: rtl/a2_fifo_sync.sv
// Generic synchronous FIFO with registered storage and an occupancy count.
// Latency: a pushed word is at the head one cycle later; rdata is the head, read combinationally.
// Backpressure: push ignored when full (no same-cycle pass-through), pop ignored when empty.
module a2_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage is cleared too so the head reads 0 straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/a2_demux_1_2_buf.sv
// Buffered 1:2 demux: steers one valid/ready stream into one of two per-output FIFOs by in_sel.
// Latency: 1 cycle from acceptance to outK_valid/outK_data.
// Backpressure: in_ready = !full of the selected FIFO only; independent of outK_ready.
module a2_demux_1_2_buf
    import a2_pkg::*;
#(
    parameter int WIDTH = A2_DATA_W,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sel,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out0_valid,
    input  logic                   out0_ready,
    output logic [WIDTH-1:0]       out0_data,
    output logic [$clog2(DEPTH):0] out0_count,
    output logic                   out1_valid,
    input  logic                   out1_ready,
    output logic [WIDTH-1:0]       out1_data,
    output logic [$clog2(DEPTH):0] out1_count
);

    logic full0, full1;
    logic empty0, empty1;
    logic push0, push1;
    logic pop0, pop1;

    // Only the selected FIFO's full flag gates acceptance, keeping consumer ready off this path.
    assign in_ready = (in_sel == A2_SEL_OUT1) ? !full1 : !full0;
    assign push0    = in_valid && in_ready && (in_sel == A2_SEL_OUT0);
    assign push1    = in_valid && in_ready && (in_sel == A2_SEL_OUT1);

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;
    assign pop0       = out0_valid && out0_ready;
    assign pop1       = out1_valid && out1_ready;

    a2_fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (push0),
        .wdata (in_data),
        .pop   (pop0),
        .rdata (out0_data),
        .full  (full0),
        .empty (empty0),
        .count (out0_count)
    );

    a2_fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (push1),
        .wdata (in_data),
        .pop   (pop1),
        .rdata (out1_data),
        .full  (full1),
        .empty (empty1),
        .count (out1_count)
    );

endmodule

// File: tb/tb_a2_demux_1_2_buf.sv
// Directed bench for a2_demux_1_2_buf: routing, backpressure, wrap, independence, reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_a2_demux_1_2_buf;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_sel;
    logic [7:0] in_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out0_data;
    logic [1:0] out0_count;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;
    logic [1:0] out1_count;

    int n_vec = 0;
    int n_err = 0;

    a2_demux_1_2_buf #(.WIDTH(8), .DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_count (out0_count),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_count (out1_count)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = 8'h00;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;

        // reset then idle
        chk_val("rst_out0_valid", 32'(out0_valid), 32'd0);
        chk_val("rst_out1_valid", 32'(out1_valid), 32'd0);
        chk_val("rst_out0_data",  32'(out0_data),  32'h00);
        chk_val("rst_out1_data",  32'(out1_data),  32'h00);
        chk_val("rst_out0_count", 32'(out0_count), 32'd0);
        chk_val("rst_out1_count", 32'(out1_count), 32'd0);
        in_sel = 1'b0; #1;
        chk_val("rst_in_ready_sel0", 32'(in_ready), 32'd1);
        in_sel = 1'b1; #1;
        chk_val("rst_in_ready_sel1", 32'(in_ready), 32'd1);

        // in_valid low writes nothing
        in_data = 8'hEE;
        step();
        chk_val("idle_out1_count", 32'(out1_count), 32'd0);
        chk_val("idle_out1_valid", 32'(out1_valid), 32'd0);

        // basic routing
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 8'h0A;
        step();
        chk_val("route_out0_valid", 32'(out0_valid), 32'd1);
        chk_val("route_out0_data",  32'(out0_data),  32'h0A);
        chk_val("route_out1_valid_a", 32'(out1_valid), 32'd0);
        in_sel  = 1'b1;
        in_data = 8'h14;
        step();
        chk_val("route_out0_empty", 32'(out0_valid), 32'd0);
        chk_val("route_out1_valid", 32'(out1_valid), 32'd1);
        chk_val("route_out1_data",  32'(out1_data),  32'h14);
        in_valid = 1'b0;
        step();
        chk_val("route_out1_empty", 32'(out1_valid), 32'd0);
        chk_val("route_out1_count", 32'(out1_count), 32'd0);

        // full / backpressure on out0
        out0_ready = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 8'h1E;
        step();
        in_data = 8'h28;
        step();
        chk_val("full_out0_count", 32'(out0_count), 32'd2);
        in_data = 8'h32;
        #1;
        chk_val("full_in_ready_sel0", 32'(in_ready), 32'd0);
        in_sel = 1'b1; #1;
        chk_val("full_in_ready_sel1", 32'(in_ready), 32'd1);
        in_sel = 1'b0; #1;
        step();
        chk_val("full_refused_count", 32'(out0_count), 32'd2);
        chk_val("full_head_1e",       32'(out0_data),  32'h1E);
        chk_val("full_out1_untouched", 32'(out1_count), 32'd0);
        out0_ready = 1'b1;
        step();
        chk_val("full_pop_count",    32'(out0_count), 32'd1);
        chk_val("full_head_28",      32'(out0_data),  32'h28);
        chk_val("full_ready_back",   32'(in_ready),   32'd1);
        out0_ready = 1'b0;
        step();
        chk_val("full_accept_32_count", 32'(out0_count), 32'd2);
        chk_val("full_head_still_28",   32'(out0_data),  32'h28);
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        step();
        chk_val("full_head_32",  32'(out0_data),  32'h32);
        chk_val("full_count_1",  32'(out0_count), 32'd1);
        step();
        chk_val("full_drained",  32'(out0_valid), 32'd0);

        // wrap-around with simultaneous push/pop on out1
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b1;
        for (int v = 1; v <= 16; v++) begin
            in_data = 8'(v);
            step();
            chk_val($sformatf("wrap_data_%0d", v), 32'(out1_data), 32'(v));
            chk_val($sformatf("wrap_count_%0d", v), 32'(out1_count), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk_val("wrap_empty", 32'(out1_valid), 32'd0);

        // cross independence: out0 full and stalled, out1 streaming
        out0_ready = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 8'hA1;
        step();
        in_data = 8'hA2;
        step();
        chk_val("cross_out0_full", 32'(out0_count), 32'd2);
        in_sel = 1'b1;
        for (int v = 0; v < 4; v++) begin
            in_data = 8'hB1 + 8'(v);
            step();
            chk_val($sformatf("cross_out1_data_%0d", v), 32'(out1_data), 32'(8'hB1 + 8'(v)));
            chk_val($sformatf("cross_out0_count_%0d", v), 32'(out0_count), 32'd2);
            chk_val($sformatf("cross_out0_head_%0d", v), 32'(out0_data), 32'hA1);
        end
        in_valid = 1'b0;
        step();

        // fill out1 with two words, then reset mid-operation
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b1;
        in_data    = 8'hC1;
        step();
        in_data = 8'hC2;
        step();
        in_valid = 1'b0;
        chk_val("mid_out1_count", 32'(out1_count), 32'd2);
        chk_val("mid_out0_count", 32'(out0_count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk_val("mid_rst_out0_valid", 32'(out0_valid), 32'd0);
        chk_val("mid_rst_out1_valid", 32'(out1_valid), 32'd0);
        chk_val("mid_rst_out0_count", 32'(out0_count), 32'd0);
        chk_val("mid_rst_out1_count", 32'(out1_count), 32'd0);
        chk_val("mid_rst_out0_data",  32'(out0_data),  32'h00);
        step();
        reset = 1'b0;
        #1;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 8'h55;
        step();
        in_valid = 1'b0;
        chk_val("post_rst_first_data",  32'(out0_data),  32'h55);
        chk_val("post_rst_first_count", 32'(out0_count), 32'd1);
        chk_val("post_rst_out1_valid",  32'(out1_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
